// File: rtl/key_filter.sv
// Debounces KEY_NUM active-low push-buttons into clean levels, one-cycle press/release
// pulses and a press-toggled level; every channel runs its own synchronizer, counter and FSM.
module key_filter #(
  parameter int CNT_MAX = 1_000_000,
  parameter int KEY_NUM = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [KEY_NUM-1:0] key_in,
  output logic [KEY_NUM-1:0] key_level,
  output logic [KEY_NUM-1:0] key_press,
  output logic [KEY_NUM-1:0] key_release,
  output logic [KEY_NUM-1:0] key_toggle
);

  localparam int CW = $clog2(CNT_MAX);
  localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_FILT,
    DOWN,
    REL_FILT
  } state_t;

  for (genvar g = 0; g < KEY_NUM; g++) begin : g_ch
    logic          sync1;
    logic          sync2;
    state_t        state;
    logic [CW-1:0] cnt;
    logic          level_q;
    logic          press_q;
    logic          release_q;
    logic          toggle_q;

    // Synchronizer resets to the released level so reset never looks like a press.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sync1 <= 1'b1;
        sync2 <= 1'b1;
      end else begin
        sync1 <= key_in[g];
        sync2 <= sync1;
      end
    end

    // Any bounce during a filter state returns to the stable state and restarts the window.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state     <= IDLE;
        cnt       <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        toggle_q  <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        case (state)
          IDLE: begin
            if (!sync2) begin
              state <= PRESS_FILT;
              cnt   <= '0;
            end
          end
          PRESS_FILT: begin
            if (sync2) begin
              state <= IDLE;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state    <= DOWN;
              cnt      <= '0;
              level_q  <= 1'b1;
              press_q  <= 1'b1;
              toggle_q <= ~toggle_q;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DOWN: begin
            if (sync2) begin
              state <= REL_FILT;
              cnt   <= '0;
            end
          end
          REL_FILT: begin
            if (!sync2) begin
              state <= DOWN;
              cnt   <= '0;
            end else if (cnt == CNT_LAST) begin
              state     <= IDLE;
              cnt       <= '0;
              level_q   <= 1'b0;
              release_q <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            cnt   <= '0;
          end
        endcase
      end
    end

    assign key_level[g]   = level_q;
    assign key_press[g]   = press_q;
    assign key_release[g] = release_q;
    assign key_toggle[g]  = toggle_q;
  end

endmodule

// File: doc/key_filter.md
KEY_FILTER -- requirements
Module: key_filter

Interface
REQ-001 The block SHALL have parameter CNT_MAX, default 1_000_000, meaning the debounce window in clock cycles (20 ms at 50 MHz), legal range 2..2^24-1.
REQ-002 The block SHALL have parameter KEY_NUM, default 3, meaning the number of independent key channels.
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the single system clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, meaning the asynchronous, active-high reset.
REQ-005 The block SHALL have port key_in, input, KEY_NUM bits, meaning the raw, asynchronous, bouncing board keys (active-low: 0 = pressed).
REQ-006 The block SHALL have port key_level, output, KEY_NUM bits, meaning the debounced key state (active-high: 1 = held).
REQ-007 The block SHALL have port key_press, output, KEY_NUM bits, meaning a one-cycle pulse per accepted press.
REQ-008 The block SHALL have port key_release, output, KEY_NUM bits, meaning a one-cycle pulse per accepted release.
REQ-009 The block SHALL have port key_toggle, output, KEY_NUM bits, meaning a level that inverts on each accepted press; it drives the team's logic-gate inputs from push-buttons.

Function
REQ-010 Each channel SHALL be fully independent: its own 2-flop synchronizer, counter and FSM, with no shared state.
REQ-011 Each synchronizer SHALL use two flops clocked by clk; the FSM SHALL sample only the second flop (sync2), never key_in directly.
REQ-012 Each counter SHALL be ceil(log2(CNT_MAX)) bits wide, SHALL never exceed CNT_MAX-1, and SHALL not wrap.
REQ-013 The FSM states SHALL be IDLE, PRESS_FILT, DOWN and REL_FILT.
REQ-014 In IDLE with sync2=0, the FSM SHALL go to PRESS_FILT with cnt cleared; otherwise it SHALL stay in IDLE.
REQ-015 In PRESS_FILT with sync2=1, the FSM SHALL return to IDLE with cnt cleared and generate no pulse.
REQ-016 In PRESS_FILT with sync2=0: if cnt<CNT_MAX-1, cnt SHALL increment; if cnt==CNT_MAX-1, the FSM SHALL go to DOWN, clear cnt, set key_level=1, pulse key_press and invert key_toggle.
REQ-017 In DOWN with sync2=1, the FSM SHALL go to REL_FILT with cnt cleared; otherwise it SHALL stay in DOWN.
REQ-018 In REL_FILT with sync2=0, the FSM SHALL return to DOWN with cnt cleared and generate no pulse.
REQ-019 In REL_FILT with sync2=1: if cnt<CNT_MAX-1, cnt SHALL increment; if cnt==CNT_MAX-1, the FSM SHALL go to IDLE, clear cnt, set key_level=0 and pulse key_release.
REQ-020 All outputs SHALL be registered.
REQ-021 key_press and key_release SHALL each be high for exactly one cycle, in the cycle after the accepting edge.
REQ-022 key_level and key_toggle SHALL update on that same edge as their pulse.
REQ-023 Press latency: with key_in held low from before edge E0, key_press SHALL be high in the cycle following edge E(CNT_MAX+2); release latency SHALL be the same.
REQ-024 A bounce shorter than CNT_MAX cycles, in either filter state, SHALL restart the window and produce no pulse and no level change.
REQ-025 key_press and key_release SHALL never both be high on the same channel; different channels MAY pulse in the same cycle.

Reset
REQ-026 While rst=1, regardless of clk: synchronizer flops SHALL be 1 (released), FSMs SHALL be IDLE, counters SHALL be 0, and key_level, key_press, key_release and key_toggle SHALL all be 0.
REQ-027 Reset asserted mid-filter or in DOWN SHALL abort the channel with no pulse.
REQ-028 After reset deasserts with a key still held, that key SHALL be accepted as a new press after the full latency.

Verification (CNT_MAX=4, KEY_NUM=3)
REQ-029 Clean press: key_in[0] 1->0 held before E0 -> key_press=3'b001 for one cycle after E6, key_level[0]=1, key_toggle[0]=1.
REQ-030 Press bounce: key_in[1] low 3 cycles, high 1, then low steady -> exactly one key_press[1] pulse, no pulse during the glitch.
REQ-031 Release: hold key_in[0], then release with one 2-cycle low glitch -> single key_release[0] pulse, key_level[0]=0, key_toggle[0] remains 1.
REQ-032 Toggle: press and release key_in[2] twice -> key_toggle[2] reads 0->1->0; two press and two release pulses total.
REQ-033 Simultaneous: key_in 3'b111->3'b000 at once -> key_press=3'b111 in the same cycle, key_level=3'b111.
REQ-034 Reset mid-filter: assert rst 2 cycles into PRESS_FILT with key_in[0] held low, release after 3 cycles -> all outputs 0 during reset, then key_press[0] 7 cycles after the first edge with rst=0.
